// File: rtl/fb_hazard_ctrl.sv
// fb_hazard_ctrl: hazard/flush sequencer for the Firebird 5-stage core.
// Drives lock, write-enable and flush controls of the PC, IF/ID, ID/EX and
// EX/MEM stage registers. Per-cycle priority: rst > mem_busy > ex_redirect
// > load-use.
// Optional macro FB_HAZARD_PERF_EN builds the stall/flush performance
// counters; without it stall_cnt and flush_cnt are tied to zero.
module fb_hazard_ctrl #(
    parameter int LOAD_LAT    = 1,  // total bubbles per load-use hazard (1..7)
    parameter int FLUSH_EXTRA = 0   // flush cycles after the redirect cycle (0..3)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_lock,
    output logic        ifid_rst,
    output logic        idex_lock,
    output logic        idex_rst,
    output logic        exmem_lock,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH, FREEZE} state_t;

    localparam logic [2:0] FE_CNT  = 3'(FLUSH_EXTRA);
    localparam logic [2:0] LL_CNT  = 3'(LOAD_LAT - 1);

    state_t     state;
    state_t     saved;   // state to resume after a memory freeze (never FREEZE)
    state_t     eff;     // state the current cycle actually decodes as
    logic [2:0] cnt;
    logic       hazard;
    logic       do_redir;
    logic       do_flush;
    logic       do_bubble;

    // Hazard detection and per-cycle action decode (FREEZE decodes as the saved state)
    always_comb begin
        eff       = (state == FREEZE) ? saved : state;
        hazard    = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
        do_redir  = !rst && !mem_busy && ex_redirect;
        do_flush  = !rst && !mem_busy && !ex_redirect && (eff == FLUSH);
        do_bubble = !rst && !mem_busy && !ex_redirect &&
                    ((eff == STALL) || ((eff == RUN) && hazard));
    end

    // Stage-register controls, combinational from state and inputs
    always_comb begin
        pc_we      = !rst && !mem_busy && !do_bubble;
        ifid_lock  = !rst && (mem_busy || do_bubble);
        ifid_we    = !ifid_lock;
        ifid_rst   = rst || do_redir || do_flush;
        idex_rst   = rst || do_redir || do_flush || do_bubble;
        idex_lock  = !rst && mem_busy;
        exmem_lock = !rst && mem_busy;
    end

    // Sequencer: freeze holds saved state and cnt; redirect aborts stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            saved <= RUN;
            cnt   <= 3'd0;
        end else if (mem_busy) begin
            if (state != FREEZE)
                saved <= state;
            state <= FREEZE;
        end else if (ex_redirect) begin
            if (FLUSH_EXTRA == 0) begin
                state <= RUN;
                cnt   <= 3'd0;
            end else begin
                state <= FLUSH;
                cnt   <= FE_CNT;
            end
        end else begin
            case (eff)
                FLUSH, STALL: begin
                    if (cnt <= 3'd1) begin
                        state <= RUN;
                        cnt   <= 3'd0;
                    end else begin
                        state <= eff;
                        cnt   <= cnt - 3'd1;
                    end
                end
                default: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state <= STALL;
                        cnt   <= LL_CNT;
                    end else begin
                        state <= RUN;
                    end
                end
            endcase
        end
    end

`ifdef FB_HAZARD_PERF_EN
    logic [31:0] stall_q;
    logic [31:0] flush_q;

    // Performance counters: load-use bubbles and flushed cycles, wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (do_bubble)
                stall_q <= stall_q + 32'd1;
            if (ifid_rst)
                flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = 32'b0;
    assign flush_cnt = 32'b0;
`endif

endmodule

// File: tb/tb_fb_hazard_ctrl.sv
// Scoreboard bench for fb_hazard_ctrl. Three instances share one stimulus:
// d0 (LOAD_LAT=1, FLUSH_EXTRA=0), d1 (3, 0), d2 (3, 2). Each directed cycle
// pushes hand-computed control vectors; a negedge monitor pops and compares.
module tb_fb_hazard_ctrl;

    // {pc_we, ifid_we, ifid_lock, ifid_rst, idex_lock, idex_rst, exmem_lock}
    localparam logic [6:0] RST = 7'b0101010;
    localparam logic [6:0] RUN = 7'b1100000;
    localparam logic [6:0] BUB = 7'b0010010;
    localparam logic [6:0] FLU = 7'b1101010;
    localparam logic [6:0] FRZ = 7'b0010101;

`ifdef FB_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [2:0][6:0]  e;
        logic [2:0][31:0] es;
        logic [2:0][31:0] ef;
        logic             chk_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst, ex_is_load, ex_redirect, mem_busy, id_use_rs1, id_use_rs2;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic [2:0][6:0]  ctrl;
    logic [2:0][31:0] sc, fc;

    exp_t sb[$];
    exp_t mx;
    int   n_chk  = 0;
    int   n_fail = 0;
    int unsigned ts[3], tf[3];
    logic known = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fb_hazard_ctrl #(
            .LOAD_LAT    ((g == 0) ? 1 : 3),
            .FLUSH_EXTRA ((g == 2) ? 2 : 0)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .id_rs1      (id_rs1),
            .id_rs2      (id_rs2),
            .id_use_rs1  (id_use_rs1),
            .id_use_rs2  (id_use_rs2),
            .ex_rd       (ex_rd),
            .ex_is_load  (ex_is_load),
            .ex_redirect (ex_redirect),
            .mem_busy    (mem_busy),
            .pc_we       (ctrl[g][6]),
            .ifid_we     (ctrl[g][5]),
            .ifid_lock   (ctrl[g][4]),
            .ifid_rst    (ctrl[g][3]),
            .idex_lock   (ctrl[g][2]),
            .idex_rst    (ctrl[g][1]),
            .exmem_lock  (ctrl[g][0]),
            .stall_cnt   (sc[g]),
            .flush_cnt   (fc[g])
        );
    end

    // kind: 0 idle, 1 rs1 hazard on x5, 2 x0 load, 3 rs2 hazard on x7,
    //       4 load x5 with no matching used operand
    task automatic row(input logic r, input logic b, input logic x, input int kind,
                       input logic [6:0] ea, input logic [6:0] eb, input logic [6:0] ec);
        exp_t t;
        @(posedge clk);
        #1;
        rst = r; mem_busy = b; ex_redirect = x;
        ex_is_load = (kind != 0);
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        case (kind)
            1: begin ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1; end
            2: begin ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; end
            3: begin ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1; end
            4: begin ex_rd = 5'd5; id_rs1 = 5'd6; id_rs2 = 5'd5; id_use_rs1 = 1'b1; end
            default: ;
        endcase
        t.e = {ec, eb, ea};
        t.chk_cnt = known;
        for (int g = 0; g < 3; g++) begin
            t.es[g] = PERF ? ts[g] : 32'd0;
            t.ef[g] = PERF ? tf[g] : 32'd0;
        end
        sb.push_back(t);
        for (int g = 0; g < 3; g++) begin
            if (r) begin
                ts[g] = 0; tf[g] = 0;
            end else begin
                if (t.e[g] == BUB) ts[g]++;
                if (t.e[g][3]) tf[g]++;
            end
        end
        if (r) known = 1'b1;
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mx = sb.pop_front();
            for (int g = 0; g < 3; g++) begin
                n_chk++;
                if (ctrl[g] !== mx.e[g]) begin
                    n_fail++;
                    $display("FAIL ctrl d%0d t=%0t got %b exp %b", g, $time, ctrl[g], mx.e[g]);
                end
                if (mx.chk_cnt) begin
                    n_chk += 2;
                    if (sc[g] !== mx.es[g]) begin
                        n_fail++;
                        $display("FAIL stall_cnt d%0d t=%0t got %0d exp %0d", g, $time, sc[g], mx.es[g]);
                    end
                    if (fc[g] !== mx.ef[g]) begin
                        n_fail++;
                        $display("FAIL flush_cnt d%0d t=%0t got %0d exp %0d", g, $time, fc[g], mx.ef[g]);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; mem_busy = 1'b0; ex_redirect = 1'b0; ex_is_load = 1'b0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        for (int g = 0; g < 3; g++) begin ts[g] = 0; tf[g] = 0; end
        //   rst busy redir kind  d0   d1   d2
        row(1, 0, 0, 0, RST, RST, RST);
        row(1, 0, 0, 0, RST, RST, RST);
        row(0, 0, 0, 0, RUN, RUN, RUN);
        // load-use on rs1: 1 bubble vs 3 bubbles
        row(0, 0, 0, 1, BUB, BUB, BUB);
        row(0, 0, 0, 0, RUN, BUB, BUB);
        row(0, 0, 0, 0, RUN, BUB, BUB);
        row(0, 0, 0, 4, RUN, RUN, RUN);
        // x0 destination never stalls
        row(0, 0, 0, 2, RUN, RUN, RUN);
        // rs2 hazard, then redirect in the 2nd stall cycle
        row(0, 0, 0, 3, BUB, BUB, BUB);
        row(0, 0, 1, 0, FLU, FLU, FLU);
        row(0, 0, 0, 0, RUN, RUN, FLU);
        row(0, 0, 0, 0, RUN, RUN, FLU);
        row(0, 0, 0, 0, RUN, RUN, RUN);
        // mem_busy for 4 cycles inside a 3-bubble stall
        row(0, 0, 0, 1, BUB, BUB, BUB);
        row(0, 1, 0, 0, FRZ, FRZ, FRZ);
        row(0, 1, 0, 1, FRZ, FRZ, FRZ);
        row(0, 1, 1, 0, FRZ, FRZ, FRZ);
        row(0, 1, 0, 0, FRZ, FRZ, FRZ);
        row(0, 0, 0, 0, RUN, BUB, BUB);
        row(0, 0, 0, 0, RUN, BUB, BUB);
        row(0, 0, 0, 0, RUN, RUN, RUN);
        // redirect during FLUSH reloads the extra-cycle count
        row(0, 0, 1, 0, FLU, FLU, FLU);
        row(0, 0, 1, 0, FLU, FLU, FLU);
        row(0, 0, 0, 0, RUN, RUN, FLU);
        row(0, 0, 0, 0, RUN, RUN, FLU);
        row(0, 0, 0, 0, RUN, RUN, RUN);
        // redirect beats load-use; freeze inside FLUSH resumes it
        row(0, 0, 1, 1, FLU, FLU, FLU);
        row(0, 1, 0, 0, FRZ, FRZ, FRZ);
        row(0, 0, 0, 0, RUN, RUN, FLU);
        row(0, 0, 0, 0, RUN, RUN, FLU);
        row(0, 0, 0, 0, RUN, RUN, RUN);
        // reset beats everything and clears counters
        row(1, 1, 1, 1, RST, RST, RST);
        row(0, 0, 0, 0, RUN, RUN, RUN);
        row(0, 0, 0, 1, BUB, BUB, BUB);
        row(0, 0, 0, 0, RUN, BUB, BUB);
        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain got %0d pending exp 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fb_hazard_ctrl.md
Name: fb_hazard_ctrl

Overview:
- Pipeline hazard and flush sequencer for the Firebird 5-stage core.
- Drives the lock/write-enable/reset controls of the PC, IF/ID, ID/EX and EX/MEM stage registers.
- Resolves load-use data hazards, control-hazard (branch mispredict) flushes and memory-busy freezes with a small FSM and counters.
- Sits beside the stage registers; its inputs come from ID decode, the EX stage and the data-memory interface.

Parameters:
- LOAD_LAT, 1: total bubble cycles inserted per load-use hazard (1..7).
- FLUSH_EXTRA, 0: extra flush cycles after a redirect cycle (0..3), covering fetch latency.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- id_rs1  in  5  ID-stage source register 1
- id_rs2  in  5  ID-stage source register 2
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  EX-stage destination register
- ex_is_load  in  1  EX instruction is a load
- ex_redirect  in  1  EX branch/jump mispredict; PC redirect this cycle
- mem_busy  in  1  data memory not ready; whole pipe must hold
- pc_we  out  1  PC write enable
- ifid_we  out  1  IF/ID write enable
- ifid_lock  out  1  IF/ID hold
- ifid_rst  out  1  IF/ID flush (clear to NOP)
- idex_lock  out  1  ID/EX hold
- idex_rst  out  1  ID/EX flush (bubble)
- exmem_lock  out  1  EX/MEM hold
- stall_cnt  out  32  performance: load-use bubble cycles
- flush_cnt  out  32  performance: flushed cycles

Behaviour:
- States: RUN, STALL, FLUSH, FREEZE. Reset state RUN; internal counter cnt (3 bits) = 0.
- Outputs are combinational from state and inputs. Stage registers sample them at the next clk edge.
- While rst=1: ifid_rst=1, idex_rst=1, pc_we=0, all locks 0, ifid_we=1.
- Default, RUN with no event: pc_we=1, ifid_we=1, all locks and rsts 0.
- Priority per cycle: rst > mem_busy > ex_redirect > load-use.
- hazard = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- mem_busy=1 (any state):
  - Outputs: pc_we=0, ifid_lock=1, idex_lock=1, exmem_lock=1, no rsts.
  - Next state FREEZE; saved state and cnt are held.
  - In FREEZE, when mem_busy=0, return to the saved state in the same cycle's decode; cnt resumes unchanged.
- ex_redirect=1 (RUN or STALL):
  - Outputs: ifid_rst=1, idex_rst=1, pc_we=1.
  - A pending stall is aborted.
  - If FLUSH_EXTRA=0, stay/go RUN. Otherwise go FLUSH with cnt=FLUSH_EXTRA.
- FLUSH:
  - Outputs: ifid_rst=1, idex_rst=1, pc_we=1.
  - cnt decrements each cycle; go RUN when cnt reaches 1.
  - A new ex_redirect reloads cnt=FLUSH_EXTRA.
- Load-use hazard in RUN:
  - Outputs: pc_we=0, ifid_lock=1, idex_rst=1.
  - If LOAD_LAT=1, stay RUN. Otherwise go STALL with cnt=LOAD_LAT-1.
- STALL:
  - Outputs are the same as for a load-use hazard.
  - cnt decrements; go RUN after the cycle in which cnt=1.
  - The hazard condition is not re-evaluated in STALL.
- Register x0 never causes a hazard.
- Counters (see Optional Feature):
  - stall_cnt increments on every cycle with idex_rst=1 caused by a load-use hazard or STALL.
  - flush_cnt increments on every cycle with ifid_rst=1 outside reset.
  - Both wrap modulo 2^32 and are cleared by rst.

Optional Feature:
- Macro FB_HAZARD_PERF_EN.
- Defined: stall_cnt and flush_cnt are implemented as described above.
- Undefined: no counter flops are built; stall_cnt and flush_cnt are tied to 32'b0.

Test Plan:
- rst=1 for 2 cycles, then idle -> during reset ifid_rst=idex_rst=1 and pc_we=0; after reset pc_we=1, ifid_we=1, all locks 0, state RUN.
- LOAD_LAT=1; ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for one cycle -> exactly 1 cycle of pc_we=0/ifid_lock=1/idex_rst=1; stall_cnt=1 (PERF_EN). Repeat with ex_rd=0 -> no stall.
- LOAD_LAT=3, same hazard -> 3 consecutive bubble cycles. ex_redirect=1 in the 2nd cycle -> that cycle ifid_rst=idex_rst=1, pc_we=1, then RUN; stall_cnt=1.
- FLUSH_EXTRA=2; ex_redirect pulse -> ifid_rst=idex_rst=1 for 3 consecutive cycles; flush_cnt=3.
- mem_busy=1 for 4 cycles in the middle of a LOAD_LAT=3 stall -> 4 cycles of all locks with pc_we=0, then the remaining stall cycles complete; total bubbles = 3.
- Build without FB_HAZARD_PERF_EN, rerun the above tests -> identical control outputs; stall_cnt=flush_cnt=0 throughout.
